mem_2p: RTL and testbench
=========================

MEM_2P -- requirements
Module: mem_2p

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 16: number of words; any value >= 2, not only powers of two.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH): address width.
REQ-004 Parameter BE_WIDTH, default WIDTH/8: number of byte-enable bits.
REQ-005 clk  input  1  sole clock; all state updates on the posedge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_addr  input  ADDR_WIDTH  write address.
REQ-009 wr_data  input  WIDTH  write data.
REQ-010 wr_be  input  BE_WIDTH  byte enables; bit i covers wr_data[8i+7:8i].
REQ-011 rd_en  input  1  read request.
REQ-012 rd_addr  input  ADDR_WIDTH  read address.
REQ-013 rd_data  output  WIDTH  registered read data.
REQ-014 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-015 init_busy  output  1  high while the clear sequence runs.

Function
REQ-016 Two-state FSM: INIT and READY.
REQ-017 INIT: an index counter SHALL write zero to entry 0, 1, ... DEPTH-1, one entry per cycle; the cycle after entry DEPTH-1 is written, the FSM moves to READY, so init_busy is high for exactly DEPTH cycles after reset release.
REQ-018 In INIT, wr_en and rd_en SHALL be ignored; rd_valid stays 0.
REQ-019 Write in READY: when wr_en=1 and wr_addr<DEPTH, each byte lane with wr_be[i]=1 SHALL update at the posedge; lanes with wr_be[i]=0 keep their value.
REQ-020 A write with wr_addr>=DEPTH or wr_be=0 SHALL leave memory unchanged.
REQ-021 Read in READY: rd_en=1 at posedge N SHALL give rd_valid=1 and rd_data=mem[rd_addr] after posedge N+1 (latency 1); rd_valid=0 in cycles with no read.
REQ-022 rd_data SHALL hold its last value when rd_valid=0.
REQ-023 A read with rd_addr>=DEPTH SHALL return all-zero rd_data with rd_valid=1.
REQ-024 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-025 Same-address read/write collision: behaviour per REQ-030/REQ-031.
REQ-026 Back-to-back reads SHALL sustain one result per cycle.

Reset
REQ-027 While rst_n=0 at a posedge: FSM=INIT, index=0, rd_data=0, rd_valid=0, init_busy=1.
REQ-028 Reset asserted during INIT or READY SHALL abort any operation and restart the full clear sequence from entry 0; a write presented in the reset cycle SHALL NOT occur.
REQ-029 Memory contents are not reset directly; they are zero only through the clear sequence.

Configuration
REQ-030 Macro MEM_BYPASS_EN defined: a collision SHALL return write-first data, i.e. old word with wr_be-enabled lanes replaced by wr_data.
REQ-031 MEM_BYPASS_EN undefined: a collision SHALL return read-first data, the pre-write word; no forwarding logic is present.

Structure
REQ-032 Shared package mem_pkg SHALL hold the FSM state enum (MEM_INIT, MEM_READY) and a byte-lane merge function used for writes and bypass.
REQ-033 A sub-module mem_init_seq SHALL hold the INIT/READY FSM and index counter, and drive the clear write address and enable and init_busy.

Verification
REQ-034 Reset release, DEPTH=16 -> init_busy high for exactly 16 cycles; reading all 16 addresses afterwards returns 0x00.
REQ-035 Write 0xA5 to addr 3 (wr_be=1), then read addr 3 -> rd_valid pulses one cycle later with rd_data=0xA5.
REQ-036 WIDTH=32: mem[5]=0x11223344; write 0xAABBCCDD with wr_be=4'b0101 -> read returns 0x11BB33DD.
REQ-037 Same-cycle write 0x5A and read of addr 7 holding 0x00 -> rd_data=0x5A with MEM_BYPASS_EN, 0x00 without; the next read returns 0x5A in both builds.
REQ-038 DEPTH=12: write to addr 13 -> no entry changes; read of addr 13 -> rd_valid=1, rd_data=0.
REQ-039 rst_n pulsed low in cycle 5 of INIT, with wr_en=1 during INIT -> clear restarts at entry 0; init_busy high for DEPTH cycles after release; no write lands.

Source files
------------

// File: rtl/mem_pkg.sv
// =============================================================================
// Module      : mem_pkg
// Description : Shared types and helpers for the mem_2p two-port memory:
//               INIT/READY state encoding and the byte-lane merge used both
//               for partial writes and for write-first read bypass.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package mem_pkg;

    // Controller states: clearing the array, or serving reads/writes
    typedef enum logic [0:0] {
        MEM_INIT  = 1'b0,
        MEM_READY = 1'b1
    } mem_state_e;

    // Widest word the merge helper supports; callers cast in and out
    localparam int MEM_MAX_WIDTH = 256;
    localparam int MEM_MAX_BE    = MEM_MAX_WIDTH / 8;

    // Replace every byte lane of old_word whose enable bit is set with the
    // matching lane of new_word; disabled lanes keep their old value.
    function automatic logic [MEM_MAX_WIDTH-1:0] mem_merge(
        input logic [MEM_MAX_WIDTH-1:0] old_word,
        input logic [MEM_MAX_WIDTH-1:0] new_word,
        input logic [MEM_MAX_BE-1:0]    be
    );
        logic [MEM_MAX_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < MEM_MAX_BE; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage : mem_pkg

`default_nettype wire

// File: rtl/mem_init_seq.sv
// =============================================================================
// Module      : mem_init_seq
// Description : INIT/READY controller for mem_2p. After reset it walks an
//               index from 0 to DEPTH-1, requesting one zero-write per cycle,
//               then parks in READY. All outputs are registered.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_init_seq
    import mem_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  clr_en_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    output logic                  init_busy_o,
    output logic                  ready_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    mem_state_e            state_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic                  busy_q;
    logic                  ready_q;

    // Clear-sequence FSM: reset always restarts the walk from entry 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MEM_INIT;
            index_q <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                MEM_INIT: begin
                    if (index_q == LAST_IDX) begin
                        state_q <= MEM_READY;
                        index_q <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        index_q <= index_q + 1'b1;
                    end
                end
                MEM_READY: begin
                    state_q <= MEM_READY;
                end
                default: begin
                    state_q <= MEM_INIT;
                    index_q <= '0;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // The clear write is active for exactly the cycles the FSM sits in INIT
    assign clr_en_o    = busy_q;
    assign clr_addr_o  = index_q;
    assign init_busy_o = busy_q;
    assign ready_o     = ready_q;

endmodule : mem_init_seq

`default_nettype wire

// File: rtl/mem_2p.sv
// =============================================================================
// Module      : mem_2p
// Description : Simple two-port (1W/1R) memory with byte enables, registered
//               read data with a one-cycle valid pulse, and a self-clear
//               sequence after every reset. Out-of-range writes are dropped,
//               out-of-range reads return zero.
// Build macro : MEM_BYPASS_EN - when defined, a same-address read/write
//               returns write-first (merged) data; otherwise read-first.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_2p
    import mem_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BE_WIDTH   = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  init_busy
);

    // -------------------------------------------------------------------------
    // Clear-sequence controller
    // -------------------------------------------------------------------------
    logic                  w_clr_en;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_ready;

    mem_init_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_en_o    (w_clr_en),
        .clr_addr_o  (w_clr_addr),
        .init_busy_o (init_busy),
        .ready_o     (w_ready)
    );

    // -------------------------------------------------------------------------
    // Storage and write path
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]      mem_q [DEPTH];

    logic                  w_wr_in_range;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic                  w_wr_fire;
    logic [WIDTH-1:0]      w_wr_merged;

    assign w_wr_in_range = (32'(wr_addr) < DEPTH);
    // Index forced to 0 when out of range so the array is never selected
    // past its end; the write itself is suppressed by w_wr_fire.
    assign w_wr_idx      = w_wr_in_range ? wr_addr : '0;
    // Writes are accepted only in READY and never in a reset cycle
    assign w_wr_fire     = rst_n & w_ready & wr_en & w_wr_in_range & (|wr_be);
    assign w_wr_merged   = WIDTH'(mem_merge(MEM_MAX_WIDTH'(mem_q[w_wr_idx]),
                                            MEM_MAX_WIDTH'(wr_data),
                                            MEM_MAX_BE'(wr_be)));

    // Array update: clear writes during INIT, merged user writes in READY
    always_ff @(posedge clk) begin
        if (rst_n && w_clr_en) begin
            mem_q[w_clr_addr] <= '0;
        end else if (w_wr_fire) begin
            mem_q[w_wr_idx] <= w_wr_merged;
        end
    end

    // -------------------------------------------------------------------------
    // Read path
    // -------------------------------------------------------------------------
    logic                  w_rd_in_range;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic                  w_rd_fire;
    logic [WIDTH-1:0]      rd_data_d;
    logic [WIDTH-1:0]      rd_data_q;
    logic                  rd_valid_q;

    assign w_rd_in_range = (32'(rd_addr) < DEPTH);
    assign w_rd_idx      = w_rd_in_range ? rd_addr : '0;
    assign w_rd_fire     = rst_n & w_ready & rd_en;

    // Next read word: array contents, zero when out of range, optional bypass
    always_comb begin
        rd_data_d = '0;
        if (w_rd_in_range) begin
            rd_data_d = mem_q[w_rd_idx];
        end
`ifdef MEM_BYPASS_EN
        if (w_wr_fire && w_rd_in_range && (wr_addr == rd_addr)) begin
            rd_data_d = w_wr_merged;
        end
`endif
    end

    // Registered read result; data holds between reads, valid is a pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= w_rd_fire;
            if (w_rd_fire) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule : mem_2p

`default_nettype wire

// File: tb/tb_mem_2p.sv
// =============================================================================
// Module      : tb_mem_2p
// Description : Directed self-checking bench for mem_2p. Instance A uses the
//               default 8x16 geometry; instance B is 32 bits wide, 12 deep.
//               Expected collision data follows MEM_BYPASS_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mem_2p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, DEPTH=16
    logic        a_rst_n = 1'b0;
    logic        a_wr_en = 1'b0;
    logic [3:0]  a_wr_addr = '0;
    logic [7:0]  a_wr_data = '0;
    logic [0:0]  a_wr_be = '0;
    logic        a_rd_en = 1'b0;
    logic [3:0]  a_rd_addr = '0;
    logic [7:0]  a_rd_data;
    logic        a_rd_valid;
    logic        a_busy;

    // Instance B: WIDTH=32, DEPTH=12
    logic        b_rst_n = 1'b0;
    logic        b_wr_en = 1'b0;
    logic [3:0]  b_wr_addr = '0;
    logic [31:0] b_wr_data = '0;
    logic [3:0]  b_wr_be = '0;
    logic        b_rd_en = 1'b0;
    logic [3:0]  b_rd_addr = '0;
    logic [31:0] b_rd_data;
    logic        b_rd_valid;
    logic        b_busy;

    int n_cmp = 0;
    int n_err = 0;

    mem_2p u_dut_a (
        .clk       (clk),
        .rst_n     (a_rst_n),
        .wr_en     (a_wr_en),
        .wr_addr   (a_wr_addr),
        .wr_data   (a_wr_data),
        .wr_be     (a_wr_be),
        .rd_en     (a_rd_en),
        .rd_addr   (a_rd_addr),
        .rd_data   (a_rd_data),
        .rd_valid  (a_rd_valid),
        .init_busy (a_busy)
    );

    mem_2p #(
        .WIDTH (32),
        .DEPTH (12)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (b_rst_n),
        .wr_en     (b_wr_en),
        .wr_addr   (b_wr_addr),
        .wr_data   (b_wr_data),
        .wr_be     (b_wr_be),
        .rd_en     (b_rd_en),
        .rd_addr   (b_rd_addr),
        .rd_data   (b_rd_data),
        .rd_valid  (b_rd_valid),
        .init_busy (b_busy)
    );

`ifdef MEM_BYPASS_EN
    localparam logic [31:0] C_COLL_EXP = 32'h5A;
`else
    localparam logic [31:0] C_COLL_EXP = 32'h00;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count rising edges until init_busy drops (bounded)
    task automatic count_busy_a(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (a_busy && n < 100);
    endtask

    task automatic count_busy_b(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (b_busy && n < 100);
    endtask

    task automatic a_write(input logic [3:0] addr, input logic [7:0] data, input logic [0:0] be);
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data; a_wr_be = be;
        tick();
        a_wr_en = 1'b0;
    endtask

    task automatic a_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        @(negedge clk);
        a_rd_en = 1'b1; a_rd_addr = addr;
        tick();
        a_rd_en = 1'b0;
        chk({tag, ".valid"}, 32'(a_rd_valid), 32'h1);
        chk({tag, ".data"}, 32'(a_rd_data), exp);
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data; b_wr_be = be;
        tick();
        b_wr_en = 1'b0;
    endtask

    task automatic b_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        @(negedge clk);
        b_rd_en = 1'b1; b_rd_addr = addr;
        tick();
        b_rd_en = 1'b0;
        chk({tag, ".valid"}, 32'(b_rd_valid), 32'h1);
        chk({tag, ".data"}, b_rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [3:0]  seq_addr [3];
        logic [31:0] seq_exp  [3];

        // ---------------- reset state ----------------
        repeat (2) tick();
        chk("a_rst.busy",  32'(a_busy),     32'h1);
        chk("a_rst.valid", 32'(a_rd_valid), 32'h0);
        chk("a_rst.data",  32'(a_rd_data),  32'h0);
        chk("b_rst.busy",  32'(b_busy),     32'h1);

        // ---------------- A: clear sequence length and contents ----------------
        @(negedge clk);
        a_rst_n = 1'b1;
        count_busy_a(n);
        chk("a_init.cycles", 32'(n), 32'd16);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_rd_en = 1'b1; a_rd_addr = 4'(i);
            tick();
            chk($sformatf("a_sweep%0d.valid", i), 32'(a_rd_valid), 32'h1);
            chk($sformatf("a_sweep%0d.data", i),  32'(a_rd_data),  32'h0);
        end
        a_rd_en = 1'b0;
        tick();
        chk("a_idle.valid", 32'(a_rd_valid), 32'h0);

        // ---------------- A: basic write/read, hold, be=0 ----------------
        a_write(4'd3, 8'hA5, 1'b1);
        a_read(4'd3, 32'hA5, "a_rd3");
        tick();
        chk("a_hold.valid", 32'(a_rd_valid), 32'h0);
        chk("a_hold.data",  32'(a_rd_data),  32'hA5);

        a_write(4'd3, 8'hFF, 1'b0);
        a_read(4'd3, 32'hA5, "a_be0");

        // ---------------- A: same-address collision ----------------
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 4'd7; a_wr_data = 8'h5A; a_wr_be = 1'b1;
        a_rd_en = 1'b1; a_rd_addr = 4'd7;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        chk("a_coll.valid", 32'(a_rd_valid), 32'h1);
        chk("a_coll.data",  32'(a_rd_data),  C_COLL_EXP);
        a_read(4'd7, 32'h5A, "a_coll_after");

        // ---------------- A: write and read different addresses together ----------------
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 4'd9; a_wr_data = 8'h3C; a_wr_be = 1'b1;
        a_rd_en = 1'b1; a_rd_addr = 4'd3;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        chk("a_dual.data", 32'(a_rd_data), 32'hA5);

        // ---------------- A: back-to-back reads ----------------
        seq_addr[0] = 4'd9; seq_exp[0] = 32'h3C;
        seq_addr[1] = 4'd7; seq_exp[1] = 32'h5A;
        seq_addr[2] = 4'd3; seq_exp[2] = 32'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_rd_en = 1'b1; a_rd_addr = seq_addr[i];
            tick();
            chk($sformatf("a_b2b%0d.valid", i), 32'(a_rd_valid), 32'h1);
            chk($sformatf("a_b2b%0d.data", i),  32'(a_rd_data),  seq_exp[i]);
        end
        a_rd_en = 1'b0;

        // ---------------- A: reset pulse mid-INIT with a write held high ----------------
        @(negedge clk);
        a_rst_n = 1'b0;
        a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 8'h77; a_wr_be = 1'b1;
        tick();
        @(negedge clk);
        a_rst_n = 1'b1;
        repeat (4) tick();
        chk("a_midinit.busy", 32'(a_busy), 32'h1);
        @(negedge clk);
        a_rst_n = 1'b0;
        tick();
        chk("a_rst2.busy",  32'(a_busy),     32'h1);
        chk("a_rst2.valid", 32'(a_rd_valid), 32'h0);
        chk("a_rst2.data",  32'(a_rd_data),  32'h0);
        @(negedge clk);
        a_rst_n = 1'b1;
        count_busy_a(n);
        a_wr_en = 1'b0;
        chk("a_reinit.cycles", 32'(n), 32'd16);
        a_read(4'd3, 32'h0, "a_reclr3");
        a_read(4'd7, 32'h0, "a_reclr7");
        a_read(4'd9, 32'h0, "a_reclr9");

        // ---------------- B: 32-bit, DEPTH=12 ----------------
        @(negedge clk);
        b_rst_n = 1'b1;
        count_busy_b(n);
        chk("b_init.cycles", 32'(n), 32'd12);

        b_write(4'd5, 32'h11223344, 4'b1111);
        b_write(4'd5, 32'hAABBCCDD, 4'b0101);
        b_read(4'd5, 32'h11BB33DD, "b_merge");

        b_write(4'd13, 32'hFFFFFFFF, 4'b1111);
        b_read(4'd13, 32'h0, "b_oor13");
        b_read(4'd5,  32'h11BB33DD, "b_keep5");
        b_read(4'd1,  32'h0, "b_keep1");
        b_read(4'd11, 32'h0, "b_keep11");
        b_read(4'd0,  32'h0, "b_keep0");

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_2p

`default_nettype wire
